aes_iter_core: RTL and testbench
================================

Name: aes_iter_core

Overview:
- Iterative, parametrised AES block engine performing one round per clock; supports both encrypt and decrypt, selected per block, for 128/192/256-bit keys.
- Takes the fully expanded key schedule from the key-expansion block and a 128-bit block over a valid/ready input handshake.
- Returns the result over a valid/ready output handshake.
- Successor to the fixed decrypt-only datapath: adds a mode select, flow control, explicit done/busy status, and a clean abort on reset.

Parameters:
- nk, 4, key length in 32-bit words; legal values 4, 6, 8.
- nr, nk+6, number of rounds; must equal nk+6; elaboration fails otherwise.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- w  input  (nr+1)*128  expanded key schedule, indexed [0:(nr+1)*128-1]; round key r = w[r*128 +: 128]; must be stable while busy.
- in_data  input  128  plaintext (encrypt) or ciphertext (decrypt).
- in_mode  input  1  0 = encrypt, 1 = decrypt; sampled with in_data.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  core can accept a block.
- out_data  output  128  result block.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  block in flight (ROUND or LAST state).

Behaviour:
- Reset (reset==0 at a rising edge):
  - state -> IDLE; round counter -> 0; state register -> 0; out_data -> 0.
  - out_valid=0, busy=0, in_ready=0 during the reset cycle, in_ready=1 after.
  - A block in flight is discarded with no output.
- States: IDLE, ROUND, LAST, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch mode; state_reg <= in_data ^ rk0, where rk0 = round key 0 for encrypt, round key nr for decrypt. Set cnt=1, go to ROUND.
- ROUND:
  - Each cycle, state_reg <= full round of state_reg with key index k.
    - Encrypt: k = cnt, using SubBytes/ShiftRows/MixColumns/AddRoundKey.
    - Decrypt: k = nr-cnt, using InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns, i.e. the existing round_inverse ordering.
  - cnt++. When cnt == nr-1 is processed, go to LAST.
- LAST:
  - Final round without (Inv)MixColumns, using round key nr (encrypt) or 0 (decrypt).
  - out_data <= result; out_valid <= 1; go to DONE.
- DONE:
  - out_valid=1; out_data held stable until out_ready.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE.
  - in_ready=0 in DONE; no new block is accepted in the handshake cycle. The next accept is the following cycle.
- Latency: acceptance edge at T. out_valid rises at edge T+nr. With continuous out_ready, throughput is one block per nr+2 cycles.
- busy=1 exactly in ROUND and LAST.
- in_ready is combinational from state only; no combinational path from in_valid or out_ready to in_ready.
- Mode is fixed per block; in_mode changes while busy are ignored.
- in_valid while not in_ready: no effect; the source holds its data.
- Reset asserted in any state takes priority over every transition.
- Round counter width: $clog2(nr+1) bits; no wrap is possible.
- No X-checks on input data in synthesizable logic.

Decomposition:
- Shared package aes_pkg:
  - AES S-box and inverse S-box functions.
  - xtime/GF multiply functions.
  - State encodings for IDLE/ROUND/LAST/DONE.
  - Function nr_of(nk) and legal-nk check.
  - Mode constants MODE_ENC=0, MODE_DEC=1.
- One sub-module, aes_round_unit (combinational):
  - Inputs: state, round key, mode, last.
  - Output: next state.
  - Wraps the forward round, round_inverse, and both last-round variants behind one mux.
  - The FSM/counter/handshake stay in aes_iter_core.

Test Plan:
- nk=4, FIPS-197 key 000102…0f, encrypt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
- nk=4, same key, decrypt 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233…eeff; mode switches enc->dec on back-to-back blocks with correct results.
- nk=6 key 000102…17: encrypt -> dda97ca4864cdfe06eaf70a0ec0d7191. nk=8 key 000102…1f: encrypt -> 8ea2b7ca516745bfeafc49904b496089. Both decrypt back, latency 12/14.
- Backpressure: hold out_ready=0 for 20 cycles. out_data stays stable, in_ready=0, a second in_valid is not accepted. Releasing out_ready gives one handshake, then in_ready=1 the next cycle.
- Reset (reset=0) asserted at round 5 -> next cycle out_valid=0, busy=0, out_data=0. A new block after reset release produces the correct FIPS-197 vector.
- in_valid pulsed while busy and in_mode toggled mid-block -> ignored; the result matches the mode latched at accept.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) arithmetic, S-boxes, FSM states, modes.
// S-box values come from the field inverse and the affine map.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_LAST,
    ST_DONE
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic bit nk_legal(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2 = gf_mul(x, x);
    x3 = gf_mul(x2, x);
    x12 = gf_mul(x3, x3);
    x12 = gf_mul(x12, x12);
    x15 = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] x,
    input int n
  );
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2)
      ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3)
      ^ rotl8(x, 6) ^ 8'h05);
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// Combinational AES round: forward, inverse and both final-round forms.
// Byte 0 of a block is bits [127:120]; columns are 4 consecutive bytes.
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         mode,
  input  logic         last,
  output logic [127:0] next
);

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {
      gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
      a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3,
      a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03),
      gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02)
    };
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {
      gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
        ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
      gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
        ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
      gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
        ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
      gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
        ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
    };
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  logic [127:0] enc_base;
  logic [127:0] dec_base;

  // Decrypt keeps the inverse-cipher order: key add before InvMixColumns
  always_comb begin
    enc_base = shift_rows(sub_bytes(state));
    dec_base = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
    next = '0;
    unique case (1'b1)
      (mode == MODE_ENC) && !last: next = mix_columns(enc_base) ^ rk;
      (mode == MODE_ENC) && last:  next = enc_base ^ rk;
      (mode == MODE_DEC) && !last: next = inv_mix_columns(dec_base);
      default:                     next = dec_base;
    endcase
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES engine, one round per clock, encrypt or decrypt per block.
// Valid/ready on both sides; the result is held until it is taken.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = nk + 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:(nr+1)*128-1]   w,
  input  logic [127:0]            in_data,
  input  logic                    in_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [127:0]            out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int CW = $clog2(nr + 1);
  localparam int AW = $clog2((nr + 1) * 128);

  if (!nk_legal(nk) || nr != nr_of(nk)) begin : g_bad_cfg
    $error("aes_iter_core: nk must be 4/6/8 and nr must be nk+6");
  end

  state_e         state;
  logic [CW-1:0]  cnt;
  logic [127:0]   st;
  logic           mode;
  logic           out_valid_q;
  logic [CW-1:0]  kidx;
  logic [AW-1:0]  base;
  logic [127:0]   rk;
  logic [127:0]   init_key;
  logic [127:0]   nxt;

  always_comb begin
    kidx = '0;
    unique case (state)
      ST_ROUND: kidx = (mode == MODE_ENC) ? cnt : CW'(nr) - cnt;
      ST_LAST:  kidx = (mode == MODE_ENC) ? CW'(nr) : '0;
      default:  kidx = '0;
    endcase
  end

  assign base     = AW'({kidx, 7'd0});
  assign rk       = w[base +: 128];
  assign init_key = (in_mode == MODE_ENC) ? w[0 +: 128] : w[nr*128 +: 128];

  aes_round_unit u_round (
    .state (st),
    .rk    (rk),
    .mode  (mode),
    .last  (state == ST_LAST),
    .next  (nxt)
  );

  // Status is forced low while reset is held so a discarded block is invisible
  assign in_ready  = reset && (state == ST_IDLE);
  assign busy      = reset && ((state == ST_ROUND) || (state == ST_LAST));
  assign out_valid = reset && out_valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      st          <= '0;
      mode        <= MODE_ENC;
      out_data    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mode  <= in_mode;
            st    <= in_data ^ init_key;
            cnt   <= CW'(1);
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          st  <= nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(nr - 1)) state <= ST_LAST;
        end
        ST_LAST: begin
          out_data    <= nxt;
          out_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboard bench for aes_iter_core with nk=4/6/8 instances.
// Expected results are FIPS-197 appendix C vectors.
module tb_aes_iter_core;
  import aes_pkg::*;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] in_data;
  logic         in_mode;
  logic         out_ready;
  logic [2:0]   iv, ir, ov, bz;
  logic [127:0] od4, od6, od8;
  logic [0:1407] w4;
  logic [0:1663] w6;
  logic [0:1919] w8;

  aes_iter_core #(.nk(4)) u4 (
    .clk(clk), .reset(reset), .w(w4), .in_data(in_data),
    .in_mode(in_mode), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_data(od4), .out_valid(ov[0]), .out_ready(out_ready),
    .busy(bz[0]));

  aes_iter_core #(.nk(6)) u6 (
    .clk(clk), .reset(reset), .w(w6), .in_data(in_data),
    .in_mode(in_mode), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_data(od6), .out_valid(ov[1]), .out_ready(out_ready),
    .busy(bz[1]));

  aes_iter_core #(.nk(8)) u8 (
    .clk(clk), .reset(reset), .w(w8), .in_data(in_data),
    .in_mode(in_mode), .in_valid(iv[2]), .in_ready(ir[2]),
    .out_data(od8), .out_valid(ov[2]), .out_ready(out_ready),
    .busy(bz[2]));

  typedef struct {
    int           dut;
    logic [127:0] data;
    int           rise;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise[3];
  logic [2:0] ov_d = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] od_of(input int i);
    case (i)
      0: return od4;
      1: return od6;
      default: return od8;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  function automatic logic [0:1919] expand(input int nk, input logic [255:0] key);
    logic [31:0] wd [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [0:1919] o;
    rc = 8'h01;
    o = '0;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) wd[i] = key[255-32*i -: 32];
      else begin
        t = wd[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        wd[i] = wd[i-nk] ^ t;
      end
      o[32*i +: 32] = wd[i];
    end
    return o;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && !ov_d[i]) rise[i] = cyc;
      if (ov[i] && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output dut%0d: got %h want none", i, od_of(i));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("out_dut%0d", i), 128'(i), 128'(e.dut));
          chk($sformatf("result_dut%0d", i), od_of(i), e.data);
          chk($sformatf("latency_dut%0d", i), 128'(rise[i]), 128'(e.rise));
        end
      end
    end
    ov_d = ov;
  end

  task automatic send(input int i, input logic [127:0] d, input logic m,
                      input logic [127:0] e, input int lat, input bit push);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_data = d;
    in_mode = m;
    iv[i] = 1'b1;
    @(negedge clk);
    while (!ir[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir[i]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got in_ready 0 want 1", i);
    end else if (push) begin
      sb.push_back('{i, e, cyc + 1 + lat});
    end
    @(posedge clk);
    #1;
    iv[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:1919] k;
    int n;
    in_data = '0;
    in_mode = MODE_ENC;
    out_ready = 1'b1;
    iv = 3'b000;
    k = expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    w4 = k[0:1407];
    k = expand(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    w6 = k[0:1663];
    k = expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    w8 = k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready%0d", i), 128'(ir[i]), 128'(0));
      chk($sformatf("rst_out_valid%0d", i), 128'(ov[i]), 128'(0));
      chk($sformatf("rst_busy%0d", i), 128'(bz[i]), 128'(0));
      chk($sformatf("rst_out_data%0d", i), od_of(i), 128'(0));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("post_rst_in_ready%0d", i), 128'(ir[i]), 128'(1));

    send(0, PT, MODE_ENC, CT128, 10, 1);
    send(0, CT128, MODE_DEC, PT, 10, 1);
    send(0, PT, MODE_ENC, CT128, 10, 1);
    send(1, PT, MODE_ENC, CT192, 12, 1);
    send(1, CT192, MODE_DEC, PT, 12, 1);
    send(2, PT, MODE_ENC, CT256, 14, 1);
    send(2, CT256, MODE_DEC, PT, 14, 1);
    drain();

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(0, PT, MODE_ENC, CT128, 10, 1);
    n = 0;
    while (!ov[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 128'(ov[0]), 128'(1));
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      iv[0] = (c >= 3 && c < 9);
      in_data = CT128;
      in_mode = MODE_DEC;
      @(negedge clk);
      chk("bp_hold_data", od4, CT128);
      chk("bp_in_ready", 128'(ir[0]), 128'(0));
      chk("bp_out_valid", 128'(ov[0]), 128'(1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", 128'(ov[0]), 128'(0));
    chk("bp_release_in_ready", 128'(ir[0]), 128'(1));
    repeat (15) @(negedge clk);
    chk("bp_no_extra_busy", 128'(bz[0]), 128'(0));

    send(0, PT, MODE_ENC, CT128, 10, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 128'(bz[0]), 128'(1));
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 128'(ir[0]), 128'(0));
    chk("abort_busy", 128'(bz[0]), 128'(0));
    chk("abort_out_valid", 128'(ov[0]), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out_data", od4, 128'(0));
    chk("abort_busy_after", 128'(bz[0]), 128'(0));
    chk("abort_valid_after", 128'(ov[0]), 128'(0));
    chk("abort_in_ready_after", 128'(ir[0]), 128'(1));
    send(0, PT, MODE_ENC, CT128, 10, 1);
    drain();

    send(0, CT128, MODE_DEC, PT, 10, 1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      in_mode = ~in_mode;
      iv[0] = ~iv[0];
      in_data = {$urandom, $urandom, $urandom, $urandom};
    end
    iv[0] = 1'b0;
    send(2, PT, MODE_ENC, CT256, 14, 1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      in_mode = ~in_mode;
      iv[2] = ~iv[2];
      in_data = {$urandom, $urandom, $urandom, $urandom};
    end
    iv[2] = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
